prog_timer: RTL and testbench



---
 rtl/prog_timer.sv | 115 +++++++++++
 tb/tb_prog_timer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_timer.sv
// Programmable down-count timer: prescaler, one-shot/periodic, sticky irq. Optional `TIMER_PAUSE_EN adds a pause input.
// Latency: done pulses (L+1)*(P+1) clocks after the start edge; no backpressure, stop beats start beats pause.
module prog_timer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  periodic,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  irq_clr,
`ifdef TIMER_PAUSE_EN
  input  logic                  pause,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  irq,
  output logic [WIDTH-1:0]      count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  state_t                  state, next_state;
  logic [PRESCALE_W-1:0]   pre_cnt;
  logic [WIDTH-1:0]        l_sh;
  logic [PRESCALE_W-1:0]   p_sh;
  logic                    per_sh;
  logic                    hold;
  logic                    tick;
  logic                    expire;

`ifdef TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
    end
  end

  always_comb begin
    next_state = state;
    tick       = 1'b0;
    expire     = 1'b0;
    if (state == RUN && !hold) begin
      tick   = (pre_cnt == p_sh);
      expire = tick && (count == '0);
    end
    if (stop)
      next_state = IDLE;
    else if (start)
      next_state = RUN;
    else if (expire && !per_sh)
      next_state = IDLE;
  end

  // Stop freezes everything; a start on an expiry edge discards that expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      pre_cnt <= '0;
      l_sh    <= '0;
      p_sh    <= '0;
      per_sh  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!stop) begin
        if (start) begin
          count   <= load_val;
          pre_cnt <= '0;
          l_sh    <= load_val;
          p_sh    <= prescale;
          per_sh  <= periodic;
        end else if (state == RUN && !hold) begin
          if (tick) begin
            pre_cnt <= '0;
            if (expire) begin
              done <= 1'b1;
              if (per_sh)
                count <= l_sh;
            end else begin
              count <= count - CNT_ONE;
            end
          end else begin
            pre_cnt <= pre_cnt + PRE_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      irq <= 1'b0;
    else if (expire && !stop && !start)
      irq <= 1'b1;
    else if (irq_clr)
      irq <= 1'b0;
  end

endmodule

// File: tb/tb_prog_timer.sv
// Directed bench for prog_timer; edge 0 is the clock edge that samples start.
module tb_prog_timer;
  localparam int W  = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, stop, periodic, irq_clr;
  logic [W-1:0]  load_val;
  logic [PW-1:0] prescale;
`ifdef TIMER_PAUSE_EN
  logic          pause;
`endif
  logic          busy, done, irq;
  logic [W-1:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  prog_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .load_val (load_val),
    .prescale (prescale),
    .irq_clr  (irq_clr),
`ifdef TIMER_PAUSE_EN
    .pause    (pause),
`endif
    .busy     (busy),
    .done     (done),
    .irq      (irq),
    .count    (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [W-1:0] l, input logic [PW-1:0] p, input logic per);
    start    = 1'b1;
    load_val = l;
    prescale = p;
    periodic = per;
    step();
    start = 1'b0;
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; start = 0; stop = 0; periodic = 0; irq_clr = 0;
    load_val = '0; prescale = '0;
`ifdef TIMER_PAUSE_EN
    pause = 1'b0;
`endif
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_irq", irq, 0);
    check("rst_count", count, 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // One-shot L=3 P=0: expiry after edge 4
    do_start(3, 0, 0);
    check("t1_busy0", busy, 1);
    check("t1_count0", count, 3);
    for (int e = 1; e <= 4; e++) begin
      step();
      check("t1_done", done, (e == 4));
    end
    check("t1_busy_end", busy, 0);
    check("t1_count_end", count, 0);
    check("t1_irq", irq, 1);
    step();
    check("t1_done_pulse", done, 0);
    check("t1_irq_sticky", irq, 1);
    clear_irq();
    check("t1_irq_clr", irq, 0);

    // Periodic L=2 P=4, inputs changed after start must be ignored
    do_start(2, 4, 1);
    load_val = 7; prescale = 0; periodic = 0;
    for (int e = 1; e <= 45; e++) begin
      step();
      check("t2_done", done, (e % 15 == 0));
      check("t2_busy", busy, 1);
      if (e % 15 == 0) check("t2_reload", count, 2);
      if (e == 5) check("t2_count5", count, 1);
    end
    stop = 1'b1; step(); stop = 1'b0;
    check("t2_stop_busy", busy, 0);
    clear_irq();

    // Stop at edge 3 freezes count; start+stop together stays idle
    do_start(5, 0, 1);
    step(); step();
    stop = 1'b1; step(); stop = 1'b0;
    check("t3_busy", busy, 0);
    check("t3_count", count, 3);
    check("t3_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_frozen", count, 3);
      check("t3_nodone", done, 0);
    end
    start = 1'b1; stop = 1'b1; load_val = 9; step(); start = 1'b0; stop = 1'b0;
    check("t3_ss_busy", busy, 0);
    check("t3_ss_count", count, 3);
    check("t3_irq", irq, 0);

    // Restart L=10 with L=1 at edge 4: done after edge 6 only
    do_start(10, 0, 0);
    step(); step(); step();
    check("t4_count3", count, 7);
    start = 1'b1; load_val = 1; step(); start = 1'b0;
    check("t4_reload", count, 1);
    for (int e = 5; e <= 12; e++) begin
      step();
      check("t4_done", done, (e == 6));
    end
    check("t4_busy", busy, 0);
    clear_irq();

    // Restart on a pending-expiry edge discards that expiry
    do_start(0, 0, 0);
    start = 1'b1; load_val = 2; step(); start = 1'b0;
    check("t4b_done", done, 0);
    check("t4b_busy", busy, 1);
    check("t4b_count", count, 2);
    check("t4b_irq", irq, 0);
    for (int e = 2; e <= 4; e++) begin
      step();
      check("t4b_done_late", done, (e == 4));
    end
    clear_irq();

    // irq set wins over irq_clr on the expiry edge
    check("t5_irq0", irq, 0);
    do_start(1, 0, 0);
    step();
    irq_clr = 1'b1;
    step();
    check("t5_done", done, 1);
    check("t5_irq_set_wins", irq, 1);
    step();
    irq_clr = 1'b0;
    check("t5_irq_cleared", irq, 0);

`ifdef TIMER_PAUSE_EN
    // Pause for edges 2..6 stretches expiry from edge 4 to edge 9
    do_start(3, 0, 0);
    for (int e = 1; e <= 10; e++) begin
      pause = (e >= 2 && e <= 6);
      step();
      check("tp_done", done, (e == 9));
      if (e >= 2 && e <= 6) begin
        check("tp_count", count, 2);
        check("tp_busy", busy, 1);
      end
    end
    pause = 1'b0;
    clear_irq();
`endif

    // Periodic L=0 P=0: done every cycle
    do_start(0, 0, 1);
    for (int e = 1; e <= 4; e++) begin
      step();
      check("t6_done", done, 1);
      check("t6_busy", busy, 1);
    end
    check("t6_irq", irq, 1);

    // Restart while running, then async reset mid-run
    do_start(100, 3, 1);
    for (int i = 0; i < 6; i++) step();
    check("t7_count", count, 99);
    check("t7_irq", irq, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_count", count, 0);
    check("t7_rst_irq", irq, 0);
    check("t7_rst_done", done, 0);
    step();
    reset_n = 1'b1;
    step(); step();
    check("t7_post_busy", busy, 0);
    check("t7_post_done", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
